// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl
// Central flow controller for the five-stage core. Owns all PC and pipeline
// register load enables and bubble resets, and picks the next-PC source.
// Disruption sources, highest priority first: data-memory back-pressure
// (freeze), taken branch in EX, load-use hazard in ID, JAL in ID, JALR in ID.
// A watchdog traps into a sticky error when the memory stays busy too long.
//
// Ports
//   clk, reset_n                 core clock (rising edge), async active-low reset
//   mem_busy                     data memory not ready -> freeze everything
//   cond_taken                   conditional branch in EX resolved taken
//   jal_id, jalr_id              JAL / JALR decoded in ID
//   ex_load, ex_rd               EX holds a load writing ex_rd
//   id_rs1, id_rs2               ID source registers
//   id_use_rs1, id_use_rs2       ID instruction actually reads that source
//   pc_sel                       000 PC+4, 001 branch, 010 JAL, 011 JALR
//   pc_le, if_id_le, pipe_le     load enables (pipe_le covers ID/EX, EX/MEM, MEM/WB)
//   if_id_reset, id_ex_reset     synchronous bubble insertion
//   err                          sticky memory-timeout error
//   stall_cnt, flush_cnt         saturating performance counters
//
// States
//   ST_RUN      | normal flow, memory ready on the previous cycle
//   ST_MEM_WAIT | memory busy streak in progress, wait_cnt counts it
//   ST_ERROR    | memory timeout trapped; pipeline frozen until reset

module pipeline_flow_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_busy,
    input  logic        cond_taken,
    input  logic        jal_id,
    input  logic        jalr_id,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    output logic [2:0]  pc_sel,
    output logic        pc_le,
    output logic        if_id_le,
    output logic        pipe_le,
    output logic        if_id_reset,
    output logic        id_ex_reset,
    output logic        err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lu_hold;
    logic       lu;
    logic       lu_stall;

    // lu_hold masks the hazard for the cycle right after the stall, when the
    // load has moved on to MEM and its result can be forwarded.
    assign lu = ex_load && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd))) &&
                !lu_hold;

    always_comb begin
        pc_sel      = 3'b000;
        pc_le       = 1'b1;
        if_id_le    = 1'b1;
        pipe_le     = 1'b1;
        if_id_reset = 1'b0;
        id_ex_reset = 1'b0;
        lu_stall    = 1'b0;
        if (!reset_n) begin
            pc_le       = 1'b0;
            if_id_le    = 1'b0;
            pipe_le     = 1'b0;
            if_id_reset = 1'b1;
            id_ex_reset = 1'b1;
        end else if (state == ST_ERROR || mem_busy) begin
            pc_le    = 1'b0;
            if_id_le = 1'b0;
            pipe_le  = 1'b0;
        end else if (cond_taken) begin
            // ID is squashed here, so a simultaneous load-use hazard is moot.
            pc_sel      = 3'b001;
            if_id_reset = 1'b1;
            id_ex_reset = 1'b1;
        end else if (lu) begin
            pc_le       = 1'b0;
            if_id_le    = 1'b0;
            id_ex_reset = 1'b1;
            lu_stall    = 1'b1;
        end else if (jal_id) begin
            pc_sel      = 3'b010;
            if_id_reset = 1'b1;
        end else if (jalr_id) begin
            pc_sel      = 3'b011;
            if_id_reset = 1'b1;
        end
    end

    assign err = (state == ST_ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            lu_hold   <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (state != ST_ERROR) begin
            if ((mem_busy || lu_stall) && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if ((pc_sel != 3'b000) && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;

            // Frozen cycles leave the hazard mask untouched.
            if (!mem_busy)
                lu_hold <= lu_stall;

            case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_busy) begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == MEM_TIMEOUT) begin
                        state <= ST_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Self-checking bench for pipeline_flow_ctrl: directed scenarios plus random
// traffic, all compared against a behavioural model of the flow rules.
module tb_pipeline_flow_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_busy = 1'b0, cond_taken = 1'b0, jal_id = 1'b0, jalr_id = 1'b0;
    logic        ex_load = 1'b0;
    logic [4:0]  ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [2:0]  pc_sel;
    logic        pc_le, if_id_le, pipe_le, if_id_reset, id_ex_reset, err;
    logic [15:0] stall_cnt, flush_cnt;

    pipeline_flow_ctrl #(.MEM_TIMEOUT(8'(TMO))) dut (
        .clk(clk), .reset_n(reset_n), .mem_busy(mem_busy), .cond_taken(cond_taken),
        .jal_id(jal_id), .jalr_id(jalr_id), .ex_load(ex_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .pc_sel(pc_sel), .pc_le(pc_le), .if_id_le(if_id_le), .pipe_le(pipe_le),
        .if_id_reset(if_id_reset), .id_ex_reset(id_ex_reset), .err(err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: busy streak length, sticky error, hazard mask, counts.
    int m_streak, m_stall, m_flush;
    bit m_err, m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_ctl();
        return {23'd0, pc_sel, pc_le, if_id_le, pipe_le, if_id_reset, id_ex_reset, err};
    endfunction

    task automatic clear_inputs();
        mem_busy = 0; cond_taken = 0; jal_id = 0; jalr_id = 0; ex_load = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    endtask

    task automatic rand_inputs();
        mem_busy   = ($urandom_range(0, 3) == 0);
        cond_taken = ($urandom_range(0, 5) == 0);
        jal_id     = ($urandom_range(0, 5) == 0);
        jalr_id    = ($urandom_range(0, 5) == 0);
        ex_load    = $urandom_range(0, 1);
        ex_rd      = 5'($urandom_range(0, 3));
        id_rs1     = 5'($urandom_range(0, 3));
        id_rs2     = 5'($urandom_range(0, 3));
        id_use_rs1 = $urandom_range(0, 1);
        id_use_rs2 = $urandom_range(0, 1);
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        logic [2:0] e_sel;
        logic e_pc, e_ifid, e_pipe, e_r1, e_r2, e_lu, hz;
        #1;
        e_sel = 3'b000; e_pc = 1; e_ifid = 1; e_pipe = 1; e_r1 = 0; e_r2 = 0; e_lu = 0;
        hz = ex_load && ex_rd != 0 && !m_hold &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (m_err || mem_busy) begin
            e_pc = 0; e_ifid = 0; e_pipe = 0;
        end else if (cond_taken) begin
            e_sel = 3'b001; e_r1 = 1; e_r2 = 1;
        end else if (hz) begin
            e_pc = 0; e_ifid = 0; e_r2 = 1; e_lu = 1;
        end else if (jal_id) begin
            e_sel = 3'b010; e_r1 = 1;
        end else if (jalr_id) begin
            e_sel = 3'b011; e_r1 = 1;
        end
        check($sformatf("%s ctl", tag), obs_ctl(),
              {23'd0, e_sel, e_pc, e_ifid, e_pipe, e_r1, e_r2, m_err});
        check($sformatf("%s stall_cnt", tag), 32'(stall_cnt), 32'(m_stall));
        check($sformatf("%s flush_cnt", tag), 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        if (!m_err) begin
            if (mem_busy) begin
                if (m_stall < 65535) m_stall++;
                m_streak++;
                if (m_streak > TMO) m_err = 1;
            end else begin
                m_streak = 0;
                m_hold = e_lu;
                if (e_lu && m_stall < 65535) m_stall++;
                if (e_sel != 0 && m_flush < 65535) m_flush++;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset applied mid-cycle, with random inputs while held.
    task automatic do_reset();
        @(negedge clk);
        rand_inputs();
        #2;
        reset_n = 0;
        #1;
        check("reset ctl", obs_ctl(), {23'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("reset counters", {stall_cnt, flush_cnt}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            rand_inputs();
        end
        #1;
        check("reset held ctl", obs_ctl(), {23'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        clear_inputs();
        reset_n = 1;
        m_streak = 0; m_stall = 0; m_flush = 0; m_err = 0; m_hold = 0;
        #1;
        check("release ctl", obs_ctl(), {23'd0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        m_streak = 0; m_stall = 0; m_flush = 0; m_err = 0; m_hold = 0;
        do_reset();

        // Load-use held for two cycles stalls exactly once.
        ex_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        step("lu1");
        step("lu2");
        clear_inputs();
        step("lu3");
        check("lu stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch beats JAL and load-use; then JAL alone.
        do_reset();
        cond_taken = 1; jal_id = 1; ex_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        step("prio1");
        clear_inputs();
        jal_id = 1;
        step("prio2");
        clear_inputs();
        step("prio3");
        check("prio flush_cnt", 32'(flush_cnt), 32'd2);
        check("prio stall_cnt", 32'(stall_cnt), 32'd0);

        // Freeze defers a branch.
        do_reset();
        mem_busy = 1; cond_taken = 1;
        repeat (3) step("frz");
        mem_busy = 0;
        #1;
        check("frz branch pc_sel", 32'(pc_sel), 32'd1);
        step("frz_rel");
        clear_inputs();
        step("frz_after");
        check("frz stall_cnt", 32'(stall_cnt), 32'd3);
        check("frz flush_cnt", 32'(flush_cnt), 32'd1);

        // Timeout boundary: TMO busy cycles are tolerated, TMO+1 trap.
        do_reset();
        mem_busy = 1;
        repeat (TMO) step("tmo_ok");
        mem_busy = 0;
        step("tmo_ok_rel");
        check("tmo ok err", 32'(err), 32'd0);
        mem_busy = 1;
        repeat (TMO + 1) step("tmo_trip");
        check("tmo err", 32'(err), 32'd1);
        mem_busy = 0; cond_taken = 1; jal_id = 1;
        repeat (3) step("tmo_hold");
        check("tmo err held", 32'(err), 32'd1);
        do_reset();

        // Saturation: short busy bursts that never reach the timeout.
        for (int b = 0; b < 258; b++) begin
            mem_busy = 1;
            repeat (TMO) step("sat");
            mem_busy = 0;
            step("sat_gap");
        end
        check("sat stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
        check("sat err", 32'(err), 32'd0);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (i % 700 == 699) do_reset();
            rand_inputs();
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_flow_ctrl.md
# pipeline_flow_ctrl

Sequential pipeline-flow controller for the five-stage core. It owns every PC/pipeline-register enable and flush in one place. It arbitrates four sources of flow disruption:
- data-memory back-pressure (freeze),
- taken conditional branches resolved in EX,
- load-use hazards detected in ID,
- JAL/JALR decoded in ID.

It also emits the PC source select, runs a memory-wait timeout watchdog with a sticky error, and keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 255: maximum tolerated consecutive memory-wait cycles before the error trap (8-bit, 1..255).
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- cond_taken  in  1  conditional branch in EX resolved taken.
- jal_id  in  1  JAL in ID.
- jalr_id  in  1  JALR in ID.
- ex_load  in  1  instruction in EX is a load.
- ex_rd  in  5  EX destination register.
- id_rs1, id_rs2  in  5 each  ID source registers.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
- pc_sel  out  3  000 PC+4, 001 branch target, 010 JAL target, 011 JALR target.
- pc_le, if_id_le  out  1  load enables for PC and IF/ID.
- pipe_le  out  1  common load enable for ID/EX, EX/MEM and MEM/WB.
- if_id_reset, id_ex_reset  out  1  synchronous bubble insertion into IF/ID and ID/EX.
- err  out  1  sticky memory-timeout error.
- stall_cnt, flush_cnt  out  16 each  saturating performance counters.

## Operation
- The load-use term `lu` is 1 when all of the following hold:
  - `ex_load` is 1,
  - `ex_rd` is not 0,
  - (`id_use_rs1` and `id_rs1` equal `ex_rd`) or (`id_use_rs2` and `id_rs2` equal `ex_rd`),
  - register `lu_hold` is 0.
- State machine states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Outputs are combinational from state and inputs. Default decision: pc_sel=000, pc_le=1, if_id_le=1, pipe_le=1, if_id_reset=0, id_ex_reset=0.
- In RUN or MEM_WAIT, decisions apply in strict priority order:
  1. `mem_busy` (freeze): pc_le=0, if_id_le=0, pipe_le=0, both resets 0, pc_sel=000.
  2. `cond_taken`: pc_sel=001, if_id_reset=1, id_ex_reset=1.
  3. `lu`: pc_le=0, if_id_le=0, id_ex_reset=1, pc_sel=000.
  4. `jal_id`: pc_sel=010, if_id_reset=1.
  5. `jalr_id`: pc_sel=011, if_id_reset=1.
- In ERROR: everything is held as in a freeze, err=1 and the counters stop. Only reset_n exits ERROR.
- `lu_hold` is set on any cycle in which a load-use stall is issued and cleared on the next non-frozen cycle. A freeze cycle leaves it unchanged. As a result, one hazard stalls exactly one cycle.
- State transitions:
  - RUN with mem_busy → MEM_WAIT, wait_cnt←1.
  - MEM_WAIT with mem_busy=0 → RUN, wait_cnt←0.
  - MEM_WAIT with mem_busy=1 and wait_cnt==MEM_TIMEOUT → ERROR.
  - MEM_WAIT with mem_busy=1 otherwise: wait_cnt increments.
- Counters:
  - stall_cnt +1 on every freeze cycle and every load-use stall cycle.
  - flush_cnt +1 on every cycle with pc_sel≠000.
  - Both saturate at 0xFFFF.

## Timing
- While reset_n=0:
  - pc_le, if_id_le and pipe_le are 0.
  - if_id_reset and id_ex_reset are 1.
  - pc_sel=000 and err=0.
  - State is RUN; counters, wait_cnt and lu_hold are 0.
- Deassertion takes effect at the first rising edge after reset_n rises.
- Zero-cycle decision latency: redirects and stalls act at the same edge as the triggering input.
- err rises at the edge that closes the (MEM_TIMEOUT+1)-th consecutive busy cycle.
- A branch coinciding with freeze is deferred, not lost: the branch stays in EX and wins on the first non-busy cycle.
- A load-use hazard coinciding with a taken branch is ignored, because ID is squashed.
- Reset asserted during MEM_WAIT or ERROR returns immediately (asynchronously) to the reset values.

## Test plan
- Reset: assert reset_n=0 with random inputs → if_id_reset=1, id_ex_reset=1, pc_le=0, counters=0. Release → defaults 000/1/1/1/0/0.
- Load-use: ex_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 held for 2 cycles → exactly 1 cycle of pc_le=0 with id_ex_reset=1, then normal. stall_cnt=1.
- Priority: cond_taken=1, jal_id=1 and lu true together → pc_sel=001 with both resets 1, flush_cnt=1. Next cycle jal_id only → pc_sel=010, if_id_reset=1, flush_cnt=2.
- Freeze beats branch: mem_busy=1 for 3 cycles with cond_taken=1 → all enables 0, pc_sel=000, stall_cnt=3. On the 4th cycle mem_busy=0 → pc_sel=001.
- Timeout (MEM_TIMEOUT=4): mem_busy=1 for 4 cycles then 0 → err=0, state RUN. mem_busy=1 for 5 cycles → err=1 after the 5th edge, held with mem_busy=0 until reset_n=0.
- Saturation: preload via 65,540 freeze cycles with a large MEM_TIMEOUT using short bursts → stall_cnt=0xFFFF, no wrap.
